// File: rtl/led_pwm_blinker.sv
// LED post-processor between the PIO and the board LEDs: global PWM dimming
// plus optional blinking, configured through a 4-register Avalon-MM slave.
module led_pwm_blinker #(
   parameter int unsigned NUM_LEDS   = 10,
   parameter int unsigned PRESCALE_W = 16,
   parameter int unsigned BLINK_W    = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_LEDS-1:0] led_in,
   input  logic [1:0]          address,
   input  logic                chipselect,
   input  logic                write_n,
   input  logic [31:0]         writedata,
   output logic [31:0]         readdata,
   output logic [NUM_LEDS-1:0] led_out
);

   logic [1:0]            ctrl_q, ctrl_d;
   logic [7:0]            duty_q, duty_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [BLINK_W-1:0]    blink_reload_q, blink_reload_d;
   logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [7:0]            pwm_cnt_q, pwm_cnt_d;
   logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
   logic                  blink_phase_q, blink_phase_d;
   logic [NUM_LEDS-1:0]   led_out_q, led_out_d;

   logic wr_en, wr_ctrl, wr_duty, wr_prescale, wr_reload;
   logic tick, wrap, pwm_on;

   always_comb begin
      wr_en       = chipselect && !write_n;
      wr_ctrl     = wr_en && (address == 2'd0);
      wr_duty     = wr_en && (address == 2'd1);
      wr_prescale = wr_en && (address == 2'd2);
      wr_reload   = wr_en && (address == 2'd3);

      ctrl_d         = wr_ctrl     ? writedata[1:0]            : ctrl_q;
      duty_d         = wr_duty     ? writedata[7:0]            : duty_q;
      prescale_d     = wr_prescale ? writedata[PRESCALE_W-1:0] : prescale_q;
      blink_reload_d = wr_reload   ? writedata[BLINK_W-1:0]    : blink_reload_q;

      tick = (pre_cnt_q == prescale_q);
      if (wr_prescale || tick) begin
         pre_cnt_d = '0;
      end else begin
         pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
      end

      pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
      wrap      = tick && (pwm_cnt_q == 8'hFF);

      // Reload write wins over a wrap; a disabled blinker restarts cleanly in the on phase.
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (wr_reload || !ctrl_q[1]) begin
         blink_cnt_d   = '0;
         blink_phase_d = 1'b1;
      end else if (wrap) begin
         if (blink_cnt_q == blink_reload_q) begin
            blink_cnt_d   = '0;
            blink_phase_d = !blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
         end
      end

      pwm_on = (duty_q == 8'hFF) || (pwm_cnt_q < duty_q);
      if (ctrl_q[0]) begin
         led_out_d = led_in & {NUM_LEDS{pwm_on && blink_phase_q}};
      end else begin
         led_out_d = led_in;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata = 32'(ctrl_q);
         2'd1:    readdata = 32'(duty_q);
         2'd2:    readdata = 32'(prescale_q);
         default: readdata = 32'(blink_reload_q);
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q         <= '0;
         duty_q         <= '1;
         prescale_q     <= '0;
         blink_reload_q <= '0;
         pre_cnt_q      <= '0;
         pwm_cnt_q      <= '0;
         blink_cnt_q    <= '0;
         blink_phase_q  <= 1'b1;
         led_out_q      <= '0;
      end else begin
         ctrl_q         <= ctrl_d;
         duty_q         <= duty_d;
         prescale_q     <= prescale_d;
         blink_reload_q <= blink_reload_d;
         pre_cnt_q      <= pre_cnt_d;
         pwm_cnt_q      <= pwm_cnt_d;
         blink_cnt_q    <= blink_cnt_d;
         blink_phase_q  <= blink_phase_d;
         led_out_q      <= led_out_d;
      end
   end

   assign led_out = led_out_q;

endmodule

// File: tb/tb_led_pwm_blinker.sv
// Bench for led_pwm_blinker: count-based reference model checked every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_led_pwm_blinker;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [9:0]  led_in;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [9:0]  led_out;

   led_pwm_blinker #(.NUM_LEDS(10), .PRESCALE_W(16), .BLINK_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .led_in(led_in), .address(address),
      .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
      .readdata(readdata), .led_out(led_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: configuration plus event counts since the relevant anchor.
   logic [1:0]  m_ctrl = '0;
   int unsigned m_duty = 255, m_pre = 0, m_rel = 0;
   int unsigned anchor = 0;   // edges since reset / last PRESCALE write
   int unsigned ticks = 0;    // ticks since reset
   int unsigned w = 0;        // PWM wraps seen while blinking since last restart
   logic [9:0]  exp_led = '0;
   bit          chk_on = 1'b0;
   bit          t_tick, t_on, t_phase, t_wr;
   int unsigned t_pwm;

   initial forever begin
      @(posedge clk);
      if (!reset_n) begin
         m_ctrl = '0; m_duty = 255; m_pre = 0; m_rel = 0;
         anchor = 0; ticks = 0; w = 0; exp_led = '0;
      end else begin
         t_tick  = (anchor % (m_pre + 1)) == m_pre;
         t_pwm   = ticks % 256;
         t_on    = (m_duty == 255) || (t_pwm < m_duty);
         t_phase = !m_ctrl[1] || (((w / (m_rel + 1)) % 2) == 0);
         exp_led = (!m_ctrl[0] || (t_on && t_phase)) ? led_in : 10'h000;
         t_wr    = chipselect && !write_n;
         if (t_wr && address == 2'd3) begin
            m_rel = writedata[15:0]; w = 0;
         end else if (!m_ctrl[1]) begin
            w = 0;
         end else if (t_tick && t_pwm == 255) begin
            w++;
         end
         if (t_tick) ticks++;
         if (t_wr && address == 2'd2) begin
            m_pre = writedata[15:0]; anchor = 0;
         end else begin
            anchor++;
         end
         if (t_wr && address == 2'd0) m_ctrl = writedata[1:0];
         if (t_wr && address == 2'd1) m_duty = writedata[7:0];
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_on) chk("led_out_model", 32'(led_out), reset_n ? 32'(exp_led) : 32'h0);
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      cycles(1);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
      address = a;
      #1;
      chk(name, readdata, exp);
   endtask

   int on_cnt, falls, n;
   logic [9:0] prev;

   initial begin
      reset_n = 1'b0; led_in = 10'h2A5; address = '0;
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      chk_on = 1'b1;
      cycles(2);
      chk("reset_led_out", 32'(led_out), 32'h0);
      rd(2'd0, 32'h0,  "reset_ctrl");
      rd(2'd1, 32'hFF, "reset_duty");
      rd(2'd2, 32'h0,  "reset_prescale");
      rd(2'd3, 32'h0,  "reset_reload");
      cycles(1);
      reset_n = 1'b1;
      #1;
      chk("post_reset_before_edge", 32'(led_out), 32'h0);
      cycles(1);
      chk("post_reset_passthrough", 32'(led_out), 32'h2A5);

      // Simultaneous PIO change and config write: old config for one cycle.
      wr(2'd1, 32'h0);
      led_in = 10'h0AA;
      wr(2'd0, 32'h1);
      chk("simul_old_cfg", 32'(led_out), 32'h0AA);
      cycles(1);
      chk("simul_new_cfg", 32'(led_out), 32'h0);

      // 25% duty, tick every cycle.
      led_in = 10'h3FF;
      wr(2'd1, 32'h40);
      wr(2'd2, 32'h0);
      rd(2'd1, 32'h40, "rd_duty40");
      rd(2'd0, 32'h1,  "rd_ctrl1");
      cycles(1);
      on_cnt = 0; falls = 0; prev = led_out;
      for (int i = 0; i < 512; i++) begin
         cycles(1);
         if (led_out == 10'h3FF) on_cnt++;
         if (prev == 10'h3FF && led_out == 10'h000) falls++;
         prev = led_out;
      end
      chk("duty40_on_cycles", 32'(on_cnt), 32'd128);
      chk("duty40_runs", 32'(falls), 32'd2);

      // Duty extremes; unused writedata bits ignored.
      wr(2'd1, 32'h0);
      cycles(1);
      on_cnt = 0;
      for (int i = 0; i < 300; i++) begin
         cycles(1);
         if (led_out != 10'h000) on_cnt++;
      end
      chk("duty0_never_on", 32'(on_cnt), 32'd0);
      wr(2'd1, 32'h1234_56FF);
      rd(2'd1, 32'hFF, "rd_duty_zero_ext");
      cycles(1);
      on_cnt = 0;
      for (int i = 0; i < 300; i++) begin
         cycles(1);
         if (led_out == led_in) on_cnt++;
      end
      chk("dutyff_always_on", 32'(on_cnt), 32'd300);

      // PRESCALE rewritten mid-count.
      wr(2'd1, 32'h40);
      wr(2'd2, 32'h5);
      cycles(3);
      wr(2'd2, 32'h3);
      rd(2'd2, 32'h3, "rd_prescale3");
      on_cnt = 0;
      for (int i = 0; i < 1024; i++) begin
         cycles(1);
         if (led_out == 10'h3FF) on_cnt++;
      end
      chk("prescale3_on_cycles", 32'(on_cnt), 32'd256);

      // Blink: half period 3 PWM periods of 512 cycles.
      wr(2'd1, 32'hFF);
      wr(2'd2, 32'h1);
      wr(2'd0, 32'h3);
      wr(2'd3, 32'h2);
      rd(2'd3, 32'h2, "rd_reload2");
      cycles(1);
      chk("blink_starts_on", 32'(led_out), 32'h3FF);
      on_cnt = 0;
      for (int i = 0; i < 3072; i++) begin
         cycles(1);
         if (led_out == 10'h3FF) on_cnt++;
      end
      chk("blink_on_cycles", 32'(on_cnt), 32'd1536);
      prev = led_out; n = 0;
      while (led_out == prev && n < 4000) begin cycles(1); n++; end
      prev = led_out; n = 0;
      while (led_out == prev && n < 4000) begin cycles(1); n++; end
      chk("blink_half_period", 32'(n), 32'd1536);

      // Asynchronous reset during the blink on phase.
      led_in = 10'h155;
      n = 0;
      while (led_out != 10'h155 && n < 2000) begin cycles(1); n++; end
      chk("blink_on_before_reset", 32'(led_out), 32'h155);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_led_out", 32'(led_out), 32'h0);
      rd(2'd0, 32'h0,  "rst2_ctrl");
      rd(2'd1, 32'hFF, "rst2_duty");
      rd(2'd3, 32'h0,  "rst2_reload");
      cycles(2);
      reset_n = 1'b1;
      led_in = 10'h0F0;
      cycles(1);
      chk("after_reset_follow", 32'(led_out), 32'h0F0);
      led_in = 10'h3C3;
      #1;
      chk("no_comb_path", 32'(led_out), 32'h0F0);
      cycles(1);
      chk("after_reset_latency", 32'(led_out), 32'h3C3);
      cycles(4);

      chk_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
